// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the IF-stage program counter unit
package pc_pkg;
    localparam int          PC_WIDTH       = 32;
    localparam logic [31:0] PC_RESET_ADDR  = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_ADDR    = 32'h0000_4180;
    localparam logic [31:0] PC_IM_BASE     = 32'h0000_3000;
    localparam int          PC_IM_WORDS    = 4096;
    localparam int          PC_TRACE_DEPTH = 8;
    localparam logic [4:0]  EXC_ADEL       = 5'd4;
    typedef enum logic {KIND_ERET, KIND_BR} kind_t;
    typedef enum logic {ST_RUN, ST_HOLD} state_t;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: redirect requests, fetch address outputs and trace read port of the PC unit
interface pc_unit_if #(
    parameter int WIDTH       = 32,
    parameter int TRACE_DEPTH = 8
);
    localparam int IW = $clog2(TRACE_DEPTH);
    logic             en;
    logic             br_valid;
    logic [WIDTH-1:0] br_target;
    logic             eret_valid;
    logic [WIDTH-1:0] epc;
    logic             exc_valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus8;
    logic             fetch_exc;
    logic [4:0]       fetch_exc_code;
    logic             redirect_pending;
    logic [IW-1:0]    trace_idx;
    logic [WIDTH-1:0] trace_data;
    logic [IW:0]      trace_count;
    modport master (
        output en, br_valid, br_target, eret_valid, epc, exc_valid, trace_idx,
        input  pc, pc_plus8, fetch_exc, fetch_exc_code, redirect_pending, trace_data, trace_count
    );
    modport slave (
        input  en, br_valid, br_target, eret_valid, epc, exc_valid, trace_idx,
        output pc, pc_plus8, fetch_exc, fetch_exc_code, redirect_pending, trace_data, trace_count
    );
endinterface

// File: rtl/pc_trace_buf.sv
// pc_trace_buf: circular log of redirect targets, read back by age (0 = newest)
module pc_trace_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic [IW-1:0]    idx,
    output logic [WIDTH-1:0] data,
    output logic [IW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    wp;
    // Ring write overwriting the oldest slot; occupancy saturates at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            count <= '0;
        end else if (push) begin
            mem[wp] <= push_data;
            wp      <= wp + IW'(1);
            if (count != (IW+1)'(DEPTH)) count <= count + (IW+1)'(1);
        end
    end
    assign data = ({1'b0, idx} < count) ? mem[wp - idx - IW'(1)] : '0;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: IF-stage PC with prioritised redirects, stall capture and fetch fault flag; PC_TRACE_EN adds a redirect trace
module pc_unit import pc_pkg::*; #(
    parameter int               WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_ADDR  = WIDTH'(PC_RESET_ADDR),
    parameter logic [WIDTH-1:0] EXC_ADDR    = WIDTH'(PC_EXC_ADDR),
    parameter logic [WIDTH-1:0] IM_BASE     = WIDTH'(PC_IM_BASE),
    parameter int               IM_WORDS    = PC_IM_WORDS,
    parameter int               TRACE_DEPTH = PC_TRACE_DEPTH
) (
    input logic      clk,
    input logic      reset,
    pc_unit_if.slave bus
);
    localparam logic [WIDTH:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [WIDTH:0] IM_HI = IM_LO + ((WIDTH+1)'(IM_WORDS) << 2);
    state_t           state;
    kind_t            kind;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] target;
    logic             fexc;
    // Redirect priority: exception, ERET, branch, pending replay, then sequential
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_ADDR;
            state  <= ST_RUN;
            kind   <= KIND_BR;
            target <= '0;
        end else if (bus.exc_valid) begin
            pc    <= EXC_ADDR;
            state <= ST_RUN;
        end else if (bus.eret_valid) begin
            if (bus.en) begin
                pc    <= bus.epc;
                state <= ST_RUN;
            end else begin
                target <= bus.epc;
                kind   <= KIND_ERET;
                state  <= ST_HOLD;
            end
        end else if (bus.br_valid) begin
            if (bus.en) begin
                pc    <= bus.br_target;
                state <= ST_RUN;
            end else if (!(state == ST_HOLD && kind == KIND_ERET)) begin
                target <= bus.br_target;
                kind   <= KIND_BR;
                state  <= ST_HOLD;
            end
        end else if (bus.en) begin
            pc    <= (state == ST_HOLD) ? target : pc + WIDTH'(4);
            state <= ST_RUN;
        end
    end
    assign fexc                 = (pc[1:0] != 2'b00) || ({1'b0, pc} < IM_LO) || ({1'b0, pc} >= IM_HI);
    assign bus.pc               = pc;
    assign bus.pc_plus8         = pc + WIDTH'(8);
    assign bus.fetch_exc        = fexc;
    assign bus.fetch_exc_code   = fexc ? EXC_ADEL : 5'd0;
    assign bus.redirect_pending = state == ST_HOLD;
`ifdef PC_TRACE_EN
    logic             push;
    logic [WIDTH-1:0] push_data;
    assign push      = !reset && (bus.exc_valid || (bus.en && (bus.eret_valid || bus.br_valid || state == ST_HOLD)));
    assign push_data = bus.exc_valid ? EXC_ADDR : bus.eret_valid ? bus.epc : bus.br_valid ? bus.br_target : target;
    pc_trace_buf #(.WIDTH(WIDTH), .DEPTH(TRACE_DEPTH)) u_trace (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .idx       (bus.trace_idx),
        .data      (bus.trace_data),
        .count     (bus.trace_count)
    );
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^bus.trace_idx;
    assign bus.trace_data   = '0;
    assign bus.trace_count  = '0;
`endif
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined MIPS core's IF stage. It supersedes the plain enable/reset PC register.
- Adds prioritised redirect selection: exception vector, ERET return, branch/jump target, or sequential +4.
- A redirect that arrives while IF is stalled is captured and applied on the next enabled cycle, never dropped.
- Flags fetch-address faults (misaligned or outside instruction memory) for the CP0 exception path.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_ADDR, 32'h0000_3000, PC value after reset.
- EXC_ADDR, 32'h0000_4180, exception handler entry.
- IM_BASE, 32'h0000_3000, first valid instruction byte address.
- IM_WORDS, 4096, instruction-memory size in words. Valid range is [IM_BASE, IM_BASE+4*IM_WORDS).
- TRACE_DEPTH, 8, redirect trace entries (power of 2; used only with PC_TRACE_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- en  in  1  IF advance enable; 0 = stall.
- br_valid  in  1  branch/jump redirect request.
- br_target  in  WIDTH  branch/jump target.
- eret_valid  in  1  ERET redirect request.
- epc  in  WIDTH  return address from CP0.
- exc_valid  in  1  exception/interrupt taken.
- pc  out  WIDTH  current fetch address.
- pc_plus8  out  WIDTH  pc+8, link value (delay slot).
- fetch_exc  out  1  fetch-address fault on current pc.
- fetch_exc_code  out  5  5'd4 (AdEL) when fetch_exc=1, else 0.
- redirect_pending  out  1  a captured redirect awaits en.
- trace_idx  in  log2(TRACE_DEPTH)  trace read index, 0 = newest.
- trace_data  out  WIDTH  trace entry at trace_idx.
- trace_count  out  log2(TRACE_DEPTH)+1  valid entries, saturating at TRACE_DEPTH.

Behaviour:
- Reset (synchronous, active-high, clock clk), highest priority: pc=RESET_ADDR; pending register cleared (redirect_pending=0); trace emptied (trace_count=0). Reset mid-stall discards any pending redirect.
- State: RUN (no pending) or HOLD (pending valid, with stored target and kind ∈ {ERET, BR}). redirect_pending=1 exactly in HOLD.
- Per rising edge, first matching rule wins:
  1. exc_valid: pc<=EXC_ADDR regardless of en; pending cleared → RUN.
  2. eret_valid: if en, pc<=epc, pending cleared. If !en, capture {epc, ERET} → HOLD.
  3. br_valid: if en, pc<=br_target, pending cleared. If !en and pending kind is ERET, request ignored. Otherwise capture {br_target, BR} → HOLD.
  4. en && HOLD: pc<=pending target → RUN.
  5. en && RUN: pc<=pc+4.
  6. Otherwise pc holds.
- A new request with en=1 overrides any pending entry.
- A new request with en=0 overwrites a pending BR entry.
- Arithmetic: pc+4 and pc+8 modulo 2^WIDTH; 32'hFFFF_FFFC+4 → 0.
- fetch_exc is combinational on pc. It is 1 if pc[1:0]≠0, pc<IM_BASE, or pc≥IM_BASE+4*IM_WORDS (comparison done in WIDTH+1 bits to avoid overflow).
- No latency beyond one edge: a redirect with en=1 is visible on pc the next cycle.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined: every applied non-sequential update (rules 1, 2/3 with en, and 4) pushes the new pc into a circular buffer of TRACE_DEPTH entries. The oldest entry is overwritten when full. trace_data = entry at age trace_idx; trace_count saturates at TRACE_DEPTH. An index ≥ trace_count reads 0.
- Not defined: no buffer storage; trace_data=0, trace_count=0; trace_idx ignored.

Decomposition:
- Shared package pc_pkg: WIDTH default, RESET_ADDR, EXC_ADDR, IM_BASE/IM_WORDS, AdEL code 5'd4, pending-kind enum {KIND_ERET, KIND_BR}.
- One sub-module: pc_trace_buf (circular buffer: write-pointer, count, indexed read), instantiated only under PC_TRACE_EN.

Test Plan:
- Reset then 3 cycles en=1 → pc 0x3000, 0x3004, 0x3008, 0x300C; pc_plus8 = pc+8; fetch_exc=0.
- en=0, br_valid=1, br_target=0x3100 for one cycle; hold 2 cycles; en=1 → pc holds while redirect_pending=1, then pc=0x3100 and pending=0.
- en=0: eret_valid (epc=0x3020), then next cycle br_valid (0x3200); en=1 → pc=0x3020 (branch ignored).
- en=0 with pending BR, exc_valid=1 → pc=0x4180 the next cycle, redirect_pending=0.
- br_target=0x3002, then br_target=0x2FFC, then 0x7000 → fetch_exc=1 with code 4 in each case; 0x6FFC → fetch_exc=0.
- With PC_TRACE_EN, TRACE_DEPTH=8: 10 redirects to 0x3000+16k (k=0..9) → trace_count=8, trace_data[idx0]=0x3090, trace_data[idx7]=0x3020; reset → trace_count=0.
